// File: rtl/step_scheduler.sv
// Tempo-driven four-voice step sequencer: phase-accumulator step clock plus per-voice patterns.
// Optional per-voice trigger mask is built when MUTE_SCHED_EN is defined (adds the mute port).
module step_scheduler #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned STEPS   = 8,
  parameter int unsigned BPM_MIN = 40,
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       bpm,
  input  logic             ld_bpm,
  input  logic [1:0]       ins_sel,
  input  logic [STEPS-1:0] pattern,
  input  logic             ld_pattern,
  input  logic             play,
`ifdef MUTE_SCHED_EN
  input  logic [3:0]       mute,
`endif
  output logic [IDX_W-1:0] step_idx,
  output logic             step_tick,
  output logic [3:0]       ins_trig,
  output logic             playing
);

  localparam logic [31:0] LIMIT     = 32'(CLK_HZ * 60);
  localparam logic [7:0]  BPM_FLOOR = 8'(BPM_MIN);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t           state;
  logic [STEPS-1:0] pat [4];
  logic [7:0]       tempo;
  logic [31:0]      acc;
  logic [31:0]      tempo_ext;
  logic             tick_due;
  logic [IDX_W-1:0] next_idx;
  logic [3:0]       hit_next;
  logic [3:0]       hit_zero;
  logic [3:0]       trig_mask;

  assign tempo_ext = {24'd0, tempo};
  // acc always stays below LIMIT, so comparing against LIMIT-tempo avoids a wider adder
  assign tick_due  = (acc >= (LIMIT - tempo_ext));
  assign next_idx  = step_idx + IDX_W'(1);

`ifdef MUTE_SCHED_EN
  assign trig_mask = ~mute;
`else
  assign trig_mask = 4'hF;
`endif

  always_comb begin
    hit_next = '0;
    hit_zero = '0;
    for (int i = 0; i < 4; i++) begin
      hit_next[i] = pat[i][next_idx];
      hit_zero[i] = pat[i][0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tempo     <= 8'd120;
      acc       <= '0;
      step_idx  <= '0;
      step_tick <= 1'b0;
      ins_trig  <= '0;
      playing   <= 1'b0;
      for (int i = 0; i < 4; i++) pat[i] <= '0;
    end else begin
      step_tick <= 1'b0;
      ins_trig  <= '0;
      // Loads land after this cycle's tick decision, so a same-cycle tick sees old values
      if (ld_bpm) tempo <= (bpm < BPM_FLOOR) ? BPM_FLOOR : bpm;
      if (ld_pattern) pat[ins_sel] <= pattern;
      case (state)
        IDLE: begin
          acc      <= '0;
          step_idx <= '0;
          playing  <= 1'b0;
          if (play) begin
            state     <= START;
            playing   <= 1'b1;
            step_tick <= 1'b1;
            ins_trig  <= hit_zero & trig_mask;
          end
        end
        START, RUN: begin
          if (state == RUN && !play) begin
            state    <= IDLE;
            acc      <= '0;
            step_idx <= '0;
            playing  <= 1'b0;
          end else begin
            state <= RUN;
            if (tick_due) begin
              acc       <= acc + tempo_ext - LIMIT;
              step_idx  <= next_idx;
              step_tick <= 1'b1;
              ins_trig  <= hit_next & trig_mask;
            end else begin
              acc <= acc + tempo_ext;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
